// File: rtl/imem_burst_reader_pkg.sv
// Shared definitions for the instruction-memory AXI read initiator.
// AXI response codes, address width and the read-master FSM state type.
package imem_burst_reader_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int AXI_LEN_W  = 8;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      AR,
      R,
      RESP
   } axi_rd_mst_state_t;

   function automatic logic resp_is_err(
      input logic [1:0] rresp
   );
      return rresp != AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/imem_burst_reader_if.sv
// AXI read address/data channels toward instruction memory.
// master = burst initiator, slave = memory responder.
interface axi_read_if;
   import imem_burst_reader_pkg::*;

   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [AXI_LEN_W-1:0]  arlen;

   logic                  rvalid;
   logic                  rready;
   logic [31:0]           rdata;
   logic                  rlast;
   logic [1:0]            rresp;

   modport master (
      output arvalid,
      output araddr,
      output arlen,
      input  arready,
      output rready,
      input  rvalid,
      input  rdata,
      input  rlast,
      input  rresp
   );

   modport slave (
      input  arvalid,
      input  araddr,
      input  arlen,
      output arready,
      input  rready,
      output rvalid,
      output rdata,
      output rlast,
      output rresp
   );

endinterface

// File: rtl/imem_burst_reader_line_buffer.sv
// Line buffer: one 32-bit slot per beat, beat-indexed write,
// synchronous clear, whole line presented as one flat vector.
module line_buffer #(
   parameter int MAX_BEATS = 8,
   parameter int IDX_W     = $clog2(MAX_BEATS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   we,
   input  logic [IDX_W-1:0]       widx,
   input  logic [31:0]            wdata,
   output logic [MAX_BEATS*32-1:0] data
);

   logic [31:0] mem [MAX_BEATS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_BEATS; i++) begin
            mem[i] <= '0;
         end
      end else if (clr) begin
         for (int i = 0; i < MAX_BEATS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   always_comb begin
      data = '0;
      for (int i = 0; i < MAX_BEATS; i++) begin
         data[i*32 +: 32] = mem[i];
      end
   end

endmodule

// File: rtl/imem_burst_reader.sv
// Instruction-memory burst reader: one AR, collect R beats, return line.
// Optional protocol checking and proto_err port: IMEM_RD_PROTO_CHECK_EN.
module imem_burst_reader
   import imem_burst_reader_pkg::*;
#(
   parameter int MAX_BEATS = 8,
   parameter int LEN_W     = $clog2(MAX_BEATS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [LEN_W-1:0]        req_len,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [MAX_BEATS*32-1:0] resp_data,
   output logic                    resp_err,
`ifdef IMEM_RD_PROTO_CHECK_EN
   output logic                    proto_err,
`endif
   axi_read_if.master              axi_if
);

   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   axi_rd_mst_state_t     state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_W-1:0]      len_q;
   logic [CNT_W-1:0]      beat_cnt;
   logic                  err_q;
   logic                  arvalid_q;
   logic                  rready_q;

   logic                  accept;
   logic                  beat_full;
   logic                  beat_wr;
   logic                  proto_bad;
   logic                  unused_addr_lsb;

   assign unused_addr_lsb = ^req_addr[1:0];

   assign accept    = (state == IDLE) && req_valid && req_ready;
   assign beat_full = beat_cnt == CNT_W'(MAX_BEATS);

`ifdef IMEM_RD_PROTO_CHECK_EN
   logic past_len;
   logic at_len;

   assign past_len = beat_cnt > CNT_W'(len_q);
   assign at_len   = beat_cnt == CNT_W'(len_q);
`endif

   always_comb begin
      beat_wr   = 1'b0;
      proto_bad = 1'b0;
      if (state == R && axi_if.rvalid) begin
         beat_wr = !beat_full;
`ifdef IMEM_RD_PROTO_CHECK_EN
         // beats past the requested length never reach the line
         if (past_len) begin
            beat_wr = 1'b0;
         end
         proto_bad = (past_len && !axi_if.rlast)
                   || (axi_if.rlast && !at_len);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         resp_valid <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt   <= '0;
         err_q      <= 1'b0;
`ifdef IMEM_RD_PROTO_CHECK_EN
         proto_err  <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  addr_q    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                  len_q     <= req_len;
                  beat_cnt  <= '0;
                  err_q     <= 1'b0;
                  req_ready <= 1'b0;
                  arvalid_q <= 1'b1;
                  state     <= AR;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            AR: begin
               if (axi_if.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= R;
               end
            end
            R: begin
               if (axi_if.rvalid) begin
                  if (beat_wr) begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
                  err_q <= err_q
                         | resp_is_err(axi_if.rresp)
                         | proto_bad;
`ifdef IMEM_RD_PROTO_CHECK_EN
                  proto_err <= proto_err | proto_bad;
`endif
                  if (axi_if.rlast) begin
                     rready_q   <= 1'b0;
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // address and length stay on the bus after AR for the responder
   assign axi_if.arvalid = arvalid_q;
   assign axi_if.araddr  = addr_q;
   assign axi_if.arlen   = AXI_LEN_W'(len_q);
   assign axi_if.rready  = rready_q;

   assign resp_err = err_q;

   line_buffer #(
      .MAX_BEATS (MAX_BEATS),
      .IDX_W     (LEN_W)
   ) u_line_buffer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .we    (beat_wr),
      .widx  (beat_cnt[LEN_W-1:0]),
      .wdata (axi_if.rdata),
      .data  (resp_data)
   );

endmodule
